// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch sequencer: state encoding,
// width helper, halt opcode default and modular address arithmetic.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int DEFAULT_ROM_SIZE = 256;
    localparam logic [8:0] DEFAULT_HALT_INSTR = 9'h1FF;

    // One extra bit beyond the ROM index so out-of-range targets are representable.
    function automatic int addr_width(input int rom_size);
        return $clog2(rom_size) + 1;
    endfunction

    // (base + offset) mod rom_size, always returning a non-negative result.
    function automatic int wrap_add(input int base, input int offset, input int rom_size);
        int sum;
        sum = (base + offset) % rom_size;
        if (sum < 0) begin
            sum = sum + rom_size;
        end
        return sum;
    endfunction

endpackage

// File: rtl/fetch_ctrl_pc_next.sv
// Next-address datapath for fetch_ctrl: sequential increment, branch
// target resolution and range checks on branch/start addresses.
module pc_next
    import fetch_pkg::*;
#(
    parameter int ROM_SIZE = DEFAULT_ROM_SIZE,
    parameter int AW       = addr_width(ROM_SIZE)
) (
    input  logic [AW-1:0] pc,
    input  logic [AW-1:0] ir_pc,
    input  logic [AW-1:0] start_addr,
    input  logic          branch_rel,
    input  logic [AW-1:0] branch_target,
    output logic [AW-1:0] pc_inc,
    output logic [AW-1:0] branch_addr,
    output logic          branch_fault,
    output logic          start_fault
);

    // Relative branches are taken from the instruction currently in IR and never fault.
    always_comb begin
        pc_inc       = AW'(wrap_add(int'(pc), 1, ROM_SIZE));
        branch_addr  = branch_target;
        branch_fault = 1'b0;
        if (branch_rel) begin
            branch_addr = AW'(wrap_add(int'(ir_pc), int'($signed(branch_target)), ROM_SIZE));
        end else begin
            branch_fault = (int'(branch_target) >= ROM_SIZE);
        end
        start_fault = (int'(start_addr) >= ROM_SIZE);
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter and fetch sequencer: drives the ROM address, captures
// the returned word into IR and handles start, stall, branch and halt.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int             ROM_SIZE   = DEFAULT_ROM_SIZE,
    parameter int             AW         = addr_width(ROM_SIZE),
    parameter logic [AW-1:0]  HALT_INSTR = AW'(DEFAULT_HALT_INSTR)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic          branch_rel,
    input  logic [AW-1:0] branch_target,
    input  logic          halt_req,
    output logic [AW-1:0] instr_addr,
    input  logic [AW-1:0] instr_in,
    output logic [AW-1:0] ir,
    output logic [AW-1:0] ir_pc,
    output logic          ir_valid,
    output logic          running,
    output logic          done,
    output logic          fault
);

    fetch_state_t  state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] ir_q, ir_d;
    logic [AW-1:0] ir_pc_q, ir_pc_d;
    logic          ir_valid_q, ir_valid_d;
    logic          fault_q, fault_d;

    logic [AW-1:0] pc_inc;
    logic [AW-1:0] branch_addr;
    logic          branch_fault;
    logic          start_fault;

    pc_next #(
        .ROM_SIZE (ROM_SIZE),
        .AW       (AW)
    ) u_pc_next (
        .pc            (pc_q),
        .ir_pc         (ir_pc_q),
        .start_addr    (start_addr),
        .branch_rel    (branch_rel),
        .branch_target (branch_target),
        .pc_inc        (pc_inc),
        .branch_addr   (branch_addr),
        .branch_fault  (branch_fault),
        .start_fault   (start_fault)
    );

    // State and fetch registers; reset aborts a run immediately with no drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            fault_q    <= fault_d;
        end
    end

    // Per-cycle action selection: halt_req beats stall beats branch beats fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        fault_d    = fault_q;

        case (state_q)
            RUN: begin
                if (halt_req) begin
                    state_d    = HALTED;
                    ir_valid_d = 1'b0;
                end else if (stall) begin
                    state_d = RUN;
                end else if (branch_taken) begin
                    ir_valid_d = 1'b0;
                    if (branch_fault) begin
                        fault_d = 1'b1;
                        state_d = HALTED;
                    end else begin
                        pc_d = branch_addr;
                    end
                end else begin
                    ir_d       = instr_in;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    if (instr_in == HALT_INSTR) begin
                        state_d = HALTED;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            default: begin
                ir_valid_d = 1'b0;
                if (start) begin
                    if (start_fault) begin
                        fault_d = 1'b1;
                        state_d = HALTED;
                    end else begin
                        pc_d    = start_addr;
                        fault_d = 1'b0;
                        state_d = RUN;
                    end
                end
            end
        endcase
    end

    assign instr_addr = pc_q;
    assign ir         = ir_q;
    assign ir_pc      = ir_pc_q;
    assign ir_valid   = ir_valid_q;
    assign fault      = fault_q;
    assign running    = (state_q == RUN);
    assign done       = (state_q == HALTED);

endmodule
